arb3_sched: RTL and testbench

ARB3_SCHED -- requirements
Module: arb3_sched

---
 rtl/arb3_sched_pkg.sv | 36 +++
 rtl/arb3_sched_rr_prio3.sv | 37 +++
 rtl/arb3_sched.sv | 103 ++++++++++
 tb/tb_arb3_sched.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/arb3_sched_pkg.sv
// rtl/arb3_sched_pkg.sv - shared types, select encodings and helpers for arb3_sched
// Contents:
//   state_e       : FSM state enum (IDLE, BUSY)
//   SEL_A/B/C     : datapath mux select encodings (00, 01, 10)
//   onehot_to_sel : one-hot owner -> select encoding
//   sel_next      : round-robin successor of an encoded requester (A->B->C->A)
package arb3_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    function automatic logic [1:0] onehot_to_sel(input logic [2:0] oh);
        logic [1:0] s;
        if (oh[2])      s = SEL_C;
        else if (oh[1]) s = SEL_B;
        else            s = SEL_A;
        return s;
    endfunction

    function automatic logic [1:0] sel_next(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            SEL_A:   n = SEL_B;
            SEL_B:   n = SEL_C;
            default: n = SEL_A;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/arb3_sched_rr_prio3.sv
// rtl/arb3_sched_rr_prio3.sv - combinational 3-way round-robin pick
// Ports:
//   req    [2:0] : request vector, bit0=A, bit1=B, bit2=C
//   ptr    [1:0] : highest-priority requester, same encoding as select
//   winner [2:0] : one-hot winner, 000 when no request
module rr_prio3
    import arb3_sched_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] winner
);

    // Priority order is ptr, ptr+1, ptr+2 (mod 3); ptr=11 is unreachable and
    // falls back to the A-first order.
    always_comb begin
        winner = 3'b000;
        case (ptr)
            SEL_B: begin
                if (req[1])      winner = 3'b010;
                else if (req[2]) winner = 3'b100;
                else if (req[0]) winner = 3'b001;
            end
            SEL_C: begin
                if (req[2])      winner = 3'b100;
                else if (req[0]) winner = 3'b001;
                else if (req[1]) winner = 3'b010;
            end
            default: begin
                if (req[0])      winner = 3'b001;
                else if (req[1]) winner = 3'b010;
                else if (req[2]) winner = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/arb3_sched.sv
// rtl/arb3_sched.sv - three-requester round-robin burst scheduler for a shared resource
// Ports:
//   clk, arst_n            : clock, asynchronous active-low reset
//   req [2:0]              : level requests, bit0=A, bit1=B, bit2=C
//   len_a/len_b/len_c      : burst length minus one, sampled only when a winner is chosen
//   mem_ready              : shared resource accepts the current beat
//   grant [2:0]            : registered one-hot owner
//   select [1:0]           : encoded owner for the datapath mux, held through IDLE
//   mem_valid              : beat presented (BUSY)
//   busy                   : burst in progress
module arb3_sched
    import arb3_sched_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [2:0]       req,
    input  logic [LEN_W-1:0] len_a,
    input  logic [LEN_W-1:0] len_b,
    input  logic [LEN_W-1:0] len_c,
    input  logic             mem_ready,
    output logic [2:0]       grant,
    output logic [1:0]       select,
    output logic             mem_valid,
    output logic             busy
);

    state_e           state_q;
    logic [2:0]       grant_q;
    logic [1:0]       sel_q;
    logic [1:0]       ptr_q;
    logic [LEN_W-1:0] cnt_q;
    logic             mem_valid_q;
    logic             busy_q;

    logic [2:0]       winner;
    logic [LEN_W-1:0] len_win;

    rr_prio3 u_rr_prio3 (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner)
    );

    always_comb begin
        len_win = len_a;
        case (winner)
            3'b010:  len_win = len_b;
            3'b100:  len_win = len_c;
            default: len_win = len_a;
        endcase
    end

    // The counter holds the remaining beats minus one, so the beat accepted
    // with cnt_q==0 is the last one and the counter never goes below zero.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            grant_q     <= 3'b000;
            sel_q       <= SEL_A;
            ptr_q       <= SEL_A;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req != 3'b000) begin
                        state_q     <= BUSY;
                        grant_q     <= winner;
                        sel_q       <= onehot_to_sel(winner);
                        cnt_q       <= len_win;
                        mem_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        if (cnt_q == '0) begin
                            // Always drop to IDLE: this enforces the idle gap
                            // between bursts. select keeps the last owner.
                            state_q     <= IDLE;
                            grant_q     <= 3'b000;
                            mem_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            ptr_q       <= sel_next(sel_q);
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign select    = sel_q;
    assign mem_valid = mem_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_arb3_sched.sv
// tb/tb_arb3_sched.sv - directed self-checking bench for arb3_sched
module tb_arb3_sched;

    localparam int LEN_W = 4;

    logic             clk;
    logic             arst_n;
    logic [2:0]       req;
    logic [LEN_W-1:0] len_a;
    logic [LEN_W-1:0] len_b;
    logic [LEN_W-1:0] len_c;
    logic             mem_ready;
    logic [2:0]       grant;
    logic [1:0]       select;
    logic             mem_valid;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int beats;

    arb3_sched #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .req       (req),
        .len_a     (len_a),
        .len_b     (len_b),
        .len_c     (len_c),
        .mem_ready (mem_ready),
        .grant     (grant),
        .select    (select),
        .mem_valid (mem_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [1:0] exp_sel);
        chk({tag, "_grant"}, grant, 3'b000);
        chk({tag, "_valid"}, mem_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_sel"}, select, exp_sel);
    endtask

    task automatic chk_busy(input string tag, input logic [2:0] exp_g, input logic [1:0] exp_sel);
        chk({tag, "_grant"}, grant, exp_g);
        chk({tag, "_valid"}, mem_valid, 1'b1);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_sel"}, select, exp_sel);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        req = 3'b000;
        tick();
        arst_n = 1'b1;
        tick();
    endtask

    logic [2:0] rr_g [7];
    logic [1:0] rr_s [7];
    logic       bp_rdy [5];

    initial begin
        rr_g = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
        rr_s = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
        bp_rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        arst_n = 1'b0; req = 3'b000; len_a = '0; len_b = '0; len_c = '0; mem_ready = 1'b0;
        #1;
        chk_idle("reset_async", 2'b00);
        tick(); tick();
        chk_idle("reset", 2'b00);
        arst_n = 1'b1;
        tick();
        chk_idle("post_reset", 2'b00);

        // Single burst A, len=3; len change after grant must be ignored.
        req = 3'b001; len_a = 4'd3; mem_ready = 1'b1;
        tick();
        chk_busy("single_b1", 3'b001, 2'b00);
        len_a = 4'd0;
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk_busy($sformatf("single_b%0d", i), 3'b001, 2'b00);
        end
        tick();
        chk_idle("single_gap", 2'b00);
        // req still held: re-granted to A even though ptr moved to B.
        tick();
        chk_busy("regrant_a", 3'b001, 2'b00);
        req = 3'b000;
        tick();
        chk_idle("regrant_end", 2'b00);
        tick();
        chk_idle("no_req", 2'b00);

        // Round-robin from ptr=A.
        do_reset();
        req = 3'b111; len_a = '0; len_b = '0; len_c = '0; mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("rr%0d_grant", i), grant, rr_g[i]);
            chk($sformatf("rr%0d_sel", i), select, rr_s[i]);
            chk($sformatf("rr%0d_valid", i), mem_valid, (rr_g[i] != 3'b000));
        end
        req = 3'b000;
        tick();
        chk_idle("rr_end", 2'b00);

        // Backpressure on B (ptr=B now), len=1.
        req = 3'b010; len_b = 4'd1; mem_ready = 1'b0;
        tick();
        req = 3'b000;
        for (int i = 0; i < 5; i++) begin
            mem_ready = bp_rdy[i];
            chk_busy($sformatf("bp%0d", i), 3'b010, 2'b01);
            tick();
        end
        chk_idle("bp_end", 2'b01);

        // Request drop on C, len=2.
        req = 3'b100; len_c = 4'd2; mem_ready = 1'b1;
        tick();
        chk_busy("drop_first", 3'b100, 2'b10);
        beats = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (!mem_valid) break;
            beats++;
            tick();
            req = 3'b000;
        end
        chk("drop_beats", beats, 3);
        chk_idle("drop_end", 2'b10);

        // Maximum length on A.
        req = 3'b001; len_a = 4'd15; mem_ready = 1'b1;
        tick();
        req = 3'b000;
        chk_busy("max_first", 3'b001, 2'b00);
        beats = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (!mem_valid) break;
            beats++;
            tick();
        end
        chk("max_beats", beats, 16);
        chk_idle("max_end", 2'b00);
        // ptr must now favour B over A.
        req = 3'b011; len_b = 4'd0;
        tick();
        req = 3'b000;
        chk_busy("ptr_after_max", 3'b010, 2'b01);
        tick();
        chk_idle("ptr_after_max_end", 2'b01);

        // Reset mid-burst: A len=5, reset after beat 2.
        do_reset();
        req = 3'b001; len_a = 4'd5; mem_ready = 1'b1;
        tick();
        req = 3'b000;
        chk_busy("mid_b1", 3'b001, 2'b00);
        tick();
        chk_busy("mid_b2", 3'b001, 2'b00);
        tick();
        arst_n = 1'b0;
        #1;
        chk_idle("mid_rst_now", 2'b00);
        tick();
        arst_n = 1'b1;
        tick();
        chk_idle("mid_after1", 2'b00);
        tick();
        chk_idle("mid_after2", 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
